eth_decap: RTL

Receive-side counterpart of the Ethernet encapsulation path. Takes raw 64-bit AXI-Stream frames from the 10G MAC RX interface and strips the 14-byte Ethernet header. Exposes dst MAC, src MAC and EtherType as sideband fields, and emits the payload realigned to byte 0 of the output stream. Also provides an optional destination-MAC filter, runt detection and status counters. Sits between the MAC RX port and the protocol-processing logic in the clk156 domain.

---
 rtl/eth_decap.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/eth_decap.sv
// rtl/eth_decap.sv - Ethernet RX header strip, payload realign, MAC filter and counters
//
// Strips the 14-byte Ethernet header from 64-bit MAC RX frames, exports the
// header fields as sideband and shifts the payload down by 6 bytes so the first
// payload byte lands on output byte 0.
//
// Ports:
//   clk156, eth_rst                  clock, synchronous active-high reset
//   s_axis_t{valid,ready,data,keep,last,user}  raw frames from the MAC
//   m_axis_t{valid,ready,data,keep,last,user}  realigned payload
//   hdr_dst, hdr_src, hdr_type       header fields of the current frame
//   cnt_frames, cnt_runt, cnt_filt   forwarded / runt / filtered frame counters
//   debug                            {3'b0, state, m_axis_tvalid, s_axis_tready}

module eth_decap #(
  parameter logic [47:0] LOCAL_MAC = 48'h000000000000,
  parameter bit          PROMISC   = 1'b1
) (
  input  logic        clk156,
  input  logic        eth_rst,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic [63:0] s_axis_tdata,
  input  logic [7:0]  s_axis_tkeep,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [63:0] m_axis_tdata,
  output logic [7:0]  m_axis_tkeep,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic [47:0] hdr_dst,
  output logic [47:0] hdr_src,
  output logic [15:0] hdr_type,
  output logic [31:0] cnt_frames,
  output logic [15:0] cnt_runt,
  output logic [15:0] cnt_filt,
  output logic [7:0]  debug
);

  typedef enum logic [2:0] {
    S_HDR0    = 3'd0,
    S_HDR1    = 3'd1,
    S_PAYLOAD = 3'd2,
    S_FLUSH   = 3'd3,
    S_DROP    = 3'd4
  } state_t;

  state_t      state;
  logic [15:0] hold;        // bytes 6-7 of the previous beat, become output bytes 0-1
  logic [1:0]  hold_keep;
  logic        user_q;      // tuser of a frame whose tail goes out in FLUSH
  logic [47:0] pend_dst;    // header bytes from word 0, published at the HDR1 accept
  logic [15:0] pend_src_hi;

  logic        slot_free;
  logic        accept;
  logic [47:0] beat_dst;
  logic        dst_ok;

  assign slot_free = !m_axis_tvalid || m_axis_tready;
  assign accept    = s_axis_tvalid && s_axis_tready;

  // Wire byte 0 is the MAC's most significant byte.
  assign beat_dst = {s_axis_tdata[7:0],   s_axis_tdata[15:8],  s_axis_tdata[23:16],
                     s_axis_tdata[31:24], s_axis_tdata[39:32], s_axis_tdata[47:40]};
  assign dst_ok   = PROMISC || (beat_dst == LOCAL_MAC) || (beat_dst == 48'hFFFF_FFFF_FFFF);

  always_comb begin
    s_axis_tready = 1'b0;
    if (!eth_rst) begin
      case (state)
        S_HDR0, S_HDR1, S_DROP: s_axis_tready = 1'b1;
        S_PAYLOAD:              s_axis_tready = slot_free;
        default:                s_axis_tready = 1'b0;
      endcase
    end
  end

  assign debug = {3'b000, state, m_axis_tvalid, s_axis_tready};

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk156) begin
    if (eth_rst) begin
      state         <= S_HDR0;
      hold          <= '0;
      hold_keep     <= '0;
      user_q        <= 1'b0;
      pend_dst      <= '0;
      pend_src_hi   <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      hdr_dst       <= '0;
      hdr_src       <= '0;
      hdr_type      <= '0;
      cnt_frames    <= '0;
      cnt_runt      <= '0;
      cnt_filt      <= '0;
    end else begin
      // A consumed beat leaves the slot; producing states below override this.
      if (m_axis_tready) m_axis_tvalid <= 1'b0;

      case (state)
        S_HDR0: begin
          if (accept) begin
            pend_dst    <= beat_dst;
            pend_src_hi <= {s_axis_tdata[55:48], s_axis_tdata[63:56]};
            if (s_axis_tlast)  cnt_runt <= sat_inc(cnt_runt);
            else if (!dst_ok)  state <= S_DROP;
            else               state <= S_HDR1;
          end
        end

        S_HDR1: begin
          if (accept) begin
            hdr_dst   <= pend_dst;
            hdr_src   <= {pend_src_hi, s_axis_tdata[7:0], s_axis_tdata[15:8],
                          s_axis_tdata[23:16], s_axis_tdata[31:24]};
            hdr_type  <= {s_axis_tdata[39:32], s_axis_tdata[47:40]};
            hold      <= s_axis_tdata[63:48];
            hold_keep <= s_axis_tkeep[7:6];
            user_q    <= s_axis_tuser;
            if (!s_axis_tlast) begin
              state <= S_PAYLOAD;
            end else if (s_axis_tkeep[6]) begin
              state <= S_FLUSH;
            end else begin
              cnt_runt <= sat_inc(cnt_runt);   // header only, no payload byte
              state    <= S_HDR0;
            end
          end
        end

        S_PAYLOAD: begin
          // accept implies the output slot is free here
          if (accept) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= {s_axis_tdata[47:0], hold};
            m_axis_tkeep  <= {s_axis_tkeep[5:0], hold_keep};
            hold          <= s_axis_tdata[63:48];
            hold_keep     <= s_axis_tkeep[7:6];
            if (s_axis_tlast && !s_axis_tkeep[6]) begin
              m_axis_tlast <= 1'b1;
              m_axis_tuser <= s_axis_tuser;
              cnt_frames   <= cnt_frames + 32'd1;
              state        <= S_HDR0;
            end else begin
              m_axis_tlast <= 1'b0;
              m_axis_tuser <= 1'b0;
              if (s_axis_tlast) begin
                // last input beat had more than 6 bytes: 1-2 bytes spill over
                user_q <= s_axis_tuser;
                state  <= S_FLUSH;
              end
            end
          end
        end

        S_FLUSH: begin
          if (slot_free) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= {48'b0, hold};
            m_axis_tkeep  <= {6'b0, hold_keep};
            m_axis_tlast  <= 1'b1;
            m_axis_tuser  <= user_q;
            cnt_frames    <= cnt_frames + 32'd1;
            state         <= S_HDR0;
          end
        end

        S_DROP: begin
          if (accept && s_axis_tlast) begin
            cnt_filt <= sat_inc(cnt_filt);
            state    <= S_HDR0;
          end
        end

        default: state <= S_HDR0;
      endcase
    end
  end

endmodule
